// File: rtl/tipi_pi_bus_ctrl_pkg.sv
// Shared constants and types for the TIPI Pi-side nibble bus controller.
// Holds command nibble encodings, FSM state encoding and default synchronizer depth.
package tipi_pkg;

    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [3:0] CMD_RD_TD = 4'h0;
    localparam logic [3:0] CMD_RD_TC = 4'h1;
    localparam logic [3:0] CMD_RD_RD = 4'h2;
    localparam logic [3:0] CMD_RD_RC = 4'h3;
    localparam logic [3:0] CMD_WR_RD = 4'h8;
    localparam logic [3:0] CMD_WR_RC = 4'h9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_HI,
        ST_RD_LO,
        ST_WR_HI,
        ST_WR_LO,
        ST_WR_COMMIT
    } state_t;

    function automatic logic is_read_cmd(input logic [3:0] cmd);
        return (cmd[3:2] == 2'b00);
    endfunction

    function automatic logic is_write_cmd(input logic [3:0] cmd);
        return (cmd[3:1] == 3'b100);
    endfunction

endpackage

// File: rtl/tipi_pi_bus_ctrl_if.sv
// Pi-facing nibble bus pins: strobe and nibble in from the Pi, nibble/oe/attention back.
// The master modport is the Pi side, the slave modport is the controller.
interface tipi_pi_bus_ctrl_if;
    logic       r_strb;
    logic [3:0] r_nib_in;
    logic [3:0] r_nib_out;
    logic       r_nib_oe;
    logic       r_attn;

    modport master (output r_strb, output r_nib_in,
                    input  r_nib_out, input r_nib_oe, input r_attn);
    modport slave  (input  r_strb, input r_nib_in,
                    output r_nib_out, output r_nib_oe, output r_attn);
endinterface

// File: rtl/tipi_sync.sv
// Multi-flop synchronizer, DEPTH cycles of latency, no flow control.
// Multi-bit use assumes the source is quasi-static around the sampling point.
module tipi_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_stg [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stg[i] <= '0;
        end else begin
            r_stg[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stg[i] <= r_stg[i-1];
        end
    end

    assign o_q = r_stg[DEPTH-1];
endmodule

// File: rtl/tipi_pi_bus_ctrl.sv
// Pi-side TIPI register exchange: command decode, byte moves in nibbles, attention, timeout.
// Outputs react SYNC_STAGES+1 cycles after a strobe rise; the Pi paces the bus, no backpressure.
module tipi_pi_bus_ctrl
    import tipi_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    tipi_pi_bus_ctrl_if.slave pi,
    input  logic [7:0]        rpi_td,
    input  logic [7:0]        rpi_tc,
    output logic [7:0]        rd_q,
    output logic [7:0]        rc_q,
    output logic              rd_we,
    output logic              rc_we,
    output logic              busy,
    output logic [7:0]        err_cnt
);
    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic       w_strb_s, r_strb_d, w_strb_evt;
    logic [7:0] w_td_s, w_tc_s, w_sel_byte;
    logic [3:0] w_nib;
    logic       w_tmo_hit, w_cmd_bad;
    state_t     r_state, w_state_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic [7:0] r_err, r_snap, r_wbuf, r_tc_seen, r_rd, r_rc;
    logic [7:0] w_snap_nxt, w_wbuf_nxt, w_tc_seen_nxt, w_rd_nxt, w_rc_nxt;
    logic [3:0] r_nib_out, w_nib_out_nxt;
    logic       r_oe, w_oe_nxt, r_wsel, w_wsel_nxt, r_attn;
    logic       r_rd_we, r_rc_we, w_rd_we_nxt, w_rc_we_nxt;

    tipi_sync #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_strb (
        .clk(sys_clk), .rst_n(sys_rst_n), .i_d(pi.r_strb), .o_q(w_strb_s));
    tipi_sync #(.WIDTH(8), .DEPTH(SYNC_STAGES)) u_sync_td (
        .clk(sys_clk), .rst_n(sys_rst_n), .i_d(rpi_td), .o_q(w_td_s));
    tipi_sync #(.WIDTH(8), .DEPTH(SYNC_STAGES)) u_sync_tc (
        .clk(sys_clk), .rst_n(sys_rst_n), .i_d(rpi_tc), .o_q(w_tc_s));

    // The Pi holds the nibble stable across the synchronizer delay, so it is sampled raw.
    assign w_nib      = pi.r_nib_in;
    assign w_strb_evt = w_strb_s & ~r_strb_d;
    assign w_tmo_hit  = (r_state != ST_IDLE) && !w_strb_evt && (r_tmo_cnt == TMO_LAST);
    assign w_cmd_bad  = (r_state == ST_IDLE) && w_strb_evt &&
                        !is_read_cmd(w_nib) && !is_write_cmd(w_nib);

    always_comb begin
        case (w_nib[1:0])
            2'd0:    w_sel_byte = w_td_s;
            2'd1:    w_sel_byte = w_tc_s;
            2'd2:    w_sel_byte = r_rd;
            default: w_sel_byte = r_rc;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_tmo_hit) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_strb_evt) begin
                    if (is_read_cmd(w_nib))       w_state_nxt = ST_RD_HI;
                    else if (is_write_cmd(w_nib)) w_state_nxt = ST_WR_HI;
                end
                ST_RD_HI:     if (w_strb_evt) w_state_nxt = ST_RD_LO;
                ST_RD_LO:     if (w_strb_evt) w_state_nxt = ST_IDLE;
                ST_WR_HI:     if (w_strb_evt) w_state_nxt = ST_WR_LO;
                ST_WR_LO:     if (w_strb_evt) w_state_nxt = ST_WR_COMMIT;
                ST_WR_COMMIT: w_state_nxt = ST_IDLE;
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_nib_out_nxt = r_nib_out;
        w_oe_nxt      = r_oe;
        w_snap_nxt    = r_snap;
        w_wbuf_nxt    = r_wbuf;
        w_wsel_nxt    = r_wsel;
        w_tc_seen_nxt = r_tc_seen;
        w_rd_nxt      = r_rd;
        w_rc_nxt      = r_rc;
        w_rd_we_nxt   = 1'b0;
        w_rc_we_nxt   = 1'b0;
        if (w_tmo_hit) begin
            w_oe_nxt      = 1'b0;
            w_nib_out_nxt = 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_strb_evt) begin
                    if (is_read_cmd(w_nib)) begin
                        w_snap_nxt    = w_sel_byte;
                        w_nib_out_nxt = w_sel_byte[7:4];
                        w_oe_nxt      = 1'b1;
                        if (w_nib == CMD_RD_TC) w_tc_seen_nxt = w_sel_byte;
                    end else if (is_write_cmd(w_nib)) begin
                        w_wsel_nxt = (w_nib == CMD_WR_RC);
                    end
                end
                ST_RD_HI: if (w_strb_evt) w_nib_out_nxt = r_snap[3:0];
                ST_RD_LO: if (w_strb_evt) begin
                    w_oe_nxt      = 1'b0;
                    w_nib_out_nxt = 4'h0;
                end
                ST_WR_HI: if (w_strb_evt) w_wbuf_nxt[7:4] = w_nib;
                ST_WR_LO: if (w_strb_evt) w_wbuf_nxt[3:0] = w_nib;
                ST_WR_COMMIT: begin
                    if (r_wsel) begin
                        w_rc_nxt    = r_wbuf;
                        w_rc_we_nxt = 1'b1;
                    end else begin
                        w_rd_nxt    = r_wbuf;
                        w_rd_we_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_nib_out <= 4'h0;
            r_oe      <= 1'b0;
            r_snap    <= 8'h00;
            r_wbuf    <= 8'h00;
            r_wsel    <= 1'b0;
            r_tc_seen <= 8'h00;
            r_rd      <= 8'h00;
            r_rc      <= 8'h00;
            r_rd_we   <= 1'b0;
            r_rc_we   <= 1'b0;
        end else begin
            r_nib_out <= w_nib_out_nxt;
            r_oe      <= w_oe_nxt;
            r_snap    <= w_snap_nxt;
            r_wbuf    <= w_wbuf_nxt;
            r_wsel    <= w_wsel_nxt;
            r_tc_seen <= w_tc_seen_nxt;
            r_rd      <= w_rd_nxt;
            r_rc      <= w_rc_nxt;
            r_rd_we   <= w_rd_we_nxt;
            r_rc_we   <= w_rc_we_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_strb_d  <= 1'b0;
            r_tmo_cnt <= '0;
            r_err     <= 8'h00;
            r_attn    <= 1'b0;
        end else begin
            r_strb_d <= w_strb_s;
            r_attn   <= (w_tc_s != r_tc_seen);
            if ((r_state == ST_IDLE) || w_strb_evt || w_tmo_hit) r_tmo_cnt <= '0;
            else                                                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if ((w_cmd_bad || w_tmo_hit) && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
        end
    end

    assign pi.r_nib_out = r_nib_out;
    assign pi.r_nib_oe  = r_oe;
    assign pi.r_attn    = r_attn;
    assign rd_q         = r_rd;
    assign rc_q         = r_rc;
    assign rd_we        = r_rd_we;
    assign rc_we        = r_rc_we;
    assign busy         = (r_state != ST_IDLE);
    assign err_cnt      = r_err;
endmodule

// File: tb/tb_tipi_pi_bus_ctrl.sv
// Scoreboard bench: Pi-side tasks push expected bytes/writes/error counts, a monitor pops on DUT activity.
module tb_tipi_pi_bus_ctrl;
    import tipi_pkg::*;

    localparam int SYNC = 2;
    localparam int TMO  = 1024;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] rpi_td, rpi_tc, rd_q, rc_q, err_cnt;
    logic       rd_we, rc_we, busy;

    tipi_pi_bus_ctrl_if pi_if();

    tipi_pi_bus_ctrl #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi(pi_if),
        .rpi_td(rpi_td), .rpi_tc(rpi_tc), .rd_q(rd_q), .rc_q(rc_q),
        .rd_we(rd_we), .rc_we(rc_we), .busy(busy), .err_cnt(err_cnt));

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       is_rc;
        logic [7:0] rd;
        logic [7:0] rc;
    } wr_exp_t;

    wr_exp_t    wr_q[$];
    logic [7:0] rdb_q[$];
    logic [7:0] err_q[$];

    // Reference model of the architecturally visible registers
    logic [7:0] m_rd, m_rc, m_seen, m_err;

    logic       mon_oe, mon_rdwe, mon_rcwe;
    logic [7:0] mon_err;
    logic [3:0] mon_hi, mon_lo;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] nib);
        @(negedge sys_clk);
        pi_if.r_nib_in = nib;
        pi_if.r_strb   = 1'b1;
        repeat (SYNC + 3) @(negedge sys_clk);
        pi_if.r_strb = 1'b0;
        repeat (SYNC + 3) @(negedge sys_clk);
    endtask

    task automatic do_read(input logic [1:0] which);
        logic [7:0] v;
        case (which)
            2'd0:    v = rpi_td;
            2'd1:    v = rpi_tc;
            2'd2:    v = m_rd;
            default: v = m_rc;
        endcase
        rdb_q.push_back(v);
        if (which == 2'd1) m_seen = v;
        strobe({2'b00, which});
        strobe(4'($urandom));
        strobe(4'($urandom));
    endtask

    task automatic do_write(input logic is_rc, input logic [7:0] v);
        wr_exp_t e;
        if (is_rc) m_rc = v;
        else       m_rd = v;
        e.is_rc = is_rc;
        e.rd    = m_rd;
        e.rc    = m_rc;
        wr_q.push_back(e);
        strobe({3'b100, is_rc});
        strobe(v[7:4]);
        strobe(v[3:0]);
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic do_illegal(input logic [3:0] c);
        if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
            err_q.push_back(m_err);
        end
        strobe(c);
    endtask

    initial begin : monitor
        wr_exp_t e;
        mon_oe = 0; mon_rdwe = 0; mon_rcwe = 0; mon_err = 0; mon_hi = 0; mon_lo = 0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                mon_oe = 0; mon_rdwe = 0; mon_rcwe = 0; mon_err = 0;
            end else begin
                if (pi_if.r_nib_oe && !mon_oe) mon_hi = pi_if.r_nib_out;
                if (pi_if.r_nib_oe) mon_lo = pi_if.r_nib_out;
                if (!pi_if.r_nib_oe && mon_oe) begin
                    if (rdb_q.size() == 0) check8("unexpected_read", {mon_hi, mon_lo}, 8'hxx);
                    else check8("read_byte", {mon_hi, mon_lo}, rdb_q.pop_front());
                end
                if (mon_rdwe || mon_rcwe)
                    check8("we_width", {6'd0, rd_we & mon_rdwe, rc_we & mon_rcwe}, 8'h00);
                if ((rd_we && !mon_rdwe) || (rc_we && !mon_rcwe)) begin
                    if (wr_q.size() == 0) begin
                        check8("unexpected_write", rd_q, 8'hxx);
                    end else begin
                        e = wr_q.pop_front();
                        check8("we_select", {6'd0, rd_we, rc_we}, {6'd0, !e.is_rc, e.is_rc});
                        check8("rd_q", rd_q, e.rd);
                        check8("rc_q", rc_q, e.rc);
                    end
                end
                if (err_cnt != mon_err) begin
                    if (err_q.size() == 0) check8("unexpected_err", err_cnt, mon_err);
                    else check8("err_cnt", err_cnt, err_q.pop_front());
                end
                mon_oe   = pi_if.r_nib_oe;
                mon_rdwe = rd_we;
                mon_rcwe = rc_we;
                mon_err  = err_cnt;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check8({tag, "_nib_out"}, {4'h0, pi_if.r_nib_out}, 8'h00);
        check8({tag, "_oe"}, {7'd0, pi_if.r_nib_oe}, 8'h00);
        check8({tag, "_rd_q"}, rd_q, 8'h00);
        check8({tag, "_rc_q"}, rc_q, 8'h00);
        check8({tag, "_we"}, {6'd0, rd_we, rc_we}, 8'h00);
        check8({tag, "_busy"}, {7'd0, busy}, 8'h00);
        check8({tag, "_err"}, err_cnt, 8'h00);
        check8({tag, "_attn"}, {7'd0, pi_if.r_attn}, 8'h00);
    endtask

    initial begin : stim
        logic [3:0] c;
        int         kind;
        pi_if.r_strb = 1'b0; pi_if.r_nib_in = 4'h0;
        rpi_td = 8'h00; rpi_tc = 8'h00;
        m_rd = 0; m_rc = 0; m_seen = 0; m_err = 0;
        repeat (3) @(negedge sys_clk);
        check_reset_vals("reset");
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        rpi_td = 8'hA5;
        repeat (4) @(negedge sys_clk);
        do_read(2'd0);
        check8("read_done_busy", {7'd0, busy}, 8'h00);
        check8("read_done_oe", {7'd0, pi_if.r_nib_oe}, 8'h00);

        do_write(1'b1, 8'h3C);
        check8("wr_rc_rd_unchanged", rd_q, 8'h00);

        check8("attn_idle", {7'd0, pi_if.r_attn}, 8'h00);
        rpi_tc = 8'h42;
        repeat (SYNC + 1) @(posedge sys_clk);
        #1 check8("attn_set", {7'd0, pi_if.r_attn}, 8'h01);
        do_read(2'd1);
        repeat (2) @(negedge sys_clk);
        check8("attn_clear", {7'd0, pi_if.r_attn}, 8'h00);
        rpi_tc = 8'h43;
        repeat (SYNC + 1) @(posedge sys_clk);
        #1 check8("attn_reset", {7'd0, pi_if.r_attn}, 8'h01);

        @(negedge sys_clk);
        rpi_td = 8'h12;
        repeat (4) @(negedge sys_clk);
        rdb_q.push_back(8'h12);
        strobe(CMD_RD_TD);
        rpi_td = 8'hF0;
        strobe(4'($urandom));
        strobe(4'($urandom));

        m_err = m_err + 8'd1;
        err_q.push_back(m_err);
        strobe(CMD_WR_RD);
        strobe(4'h7);
        for (int i = 0; i < TMO + 50 && busy; i++) @(negedge sys_clk);
        check8("timeout_busy", {7'd0, busy}, 8'h00);
        check8("timeout_rd_q", rd_q, m_rd);
        repeat (2) @(negedge sys_clk);
        check8("timeout_err", err_cnt, 8'h01);

        do_illegal(4'h5);
        check8("illegal_busy", {7'd0, busy}, 8'h00);
        check8("illegal_err", err_cnt, 8'h02);

        strobe(CMD_WR_RD);
        strobe(4'h1);
        check8("wr_lo_busy", {7'd0, busy}, 8'h01);
        #2 sys_rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        m_rd = 0; m_rc = 0; m_seen = 0; m_err = 0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        do_write(1'b0, 8'h11);
        check8("post_reset_rd_q", rd_q, 8'h11);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) rpi_tc = 8'($urandom);
            rpi_td = 8'($urandom);
            repeat (4) @(negedge sys_clk);
            kind = $urandom_range(0, 6);
            if (kind < 4) begin
                do_read(2'(kind));
            end else if (kind < 6) begin
                do_write(kind == 5, 8'($urandom));
            end else begin
                c = 4'($urandom_range(4, 15));
                if (c == 4'h8 || c == 4'h9) c = 4'hE;
                do_illegal(c);
            end
            repeat (3) @(negedge sys_clk);
            check8("rand_attn", {7'd0, pi_if.r_attn}, {7'd0, rpi_tc != m_seen});
        end

        for (int i = 0; i < 262; i++) do_illegal(4'hF);
        repeat (3) @(negedge sys_clk);
        check8("err_saturate", err_cnt, 8'hFF);

        check8("leftover_expect", 8'(rdb_q.size() + wr_q.size() + err_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
